mux_2x1_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 2-bit, 2-input selection datapath built from `mux_2x1_2bit`. Two requesters each present a request and 2-bit data. The block decides which one drives the mux `selector`, captures the mux output into an output register, and delivers it downstream with a valid/ready handshake. It sits between the two data sources and the consumer, and it is the only logic that drives the mux select line.

---
 rtl/mux_2x1_arbiter.sv | 129 ++++++++++++
 tb/tb_mux_2x1_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_2x1_arbiter.sv
// mux_2x1_2bit: 2-bit, 2-input selection cell.
//   in_0, in_1 : 2-bit data inputs
//   select     : 0 picks in_0, 1 picks in_1
//   out        : selected 2-bit word
//
// mux_2x1_arbiter: round-robin arbiter and sequencer for the shared mux.
// It picks which requester drives the mux select line, captures the mux output
// into an output register, and hands that word downstream with valid/ready.
//   clk, reset             : clock; asynchronous active-high reset
//   req0/data0, req1/data1 : requests with 2-bit payloads, held until granted
//   gnt0, gnt1             : combinational grants, high in the capture cycle
//   selector               : current mux select (0 = data0, 1 = data1)
//   out_valid, out_data    : registered output word and its valid flag
//   out_ready              : consumer accepts out_data when out_valid is high
//   xfer_count             : registered count of delivered words, wraps to 0

module mux_2x1_2bit #(
    parameter int PwrC = 0
) (
    input  logic [1:0] in_0,
    input  logic [1:0] in_1,
    input  logic       select,
    output logic [1:0] out
);

    // The power-cost annotation has no functional effect.
    logic unused_pwrc;
    assign unused_pwrc = (PwrC != 0);

    assign out = select ? in_1 : in_0;

endmodule

module mux_2x1_arbiter #(
    parameter int          PwrC  = 0,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [1:0]       data0,
    input  logic             req1,
    input  logic [1:0]       data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             selector,
    output logic             out_valid,
    output logic [1:0]       out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_count
);

    logic             last_q, last_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_data_q, out_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       sel;
    logic       cap;
    logic       deliver;
    logic [1:0] mux_out;

    mux_2x1_2bit #(
        .PwrC(PwrC)
    ) u_mux (
        .in_0  (data0),
        .in_1  (data1),
        .select(sel),
        .out   (mux_out)
    );

    always_comb begin
        sel = last_q;
        if (reset) begin
            // Keep the select line parked on requester 1 while in reset.
            sel = 1'b1;
        end else begin
            unique case ({req1, req0})
                2'b01:   sel = 1'b0;
                2'b10:   sel = 1'b1;
                2'b11:   sel = ~last_q;
                default: sel = last_q;
            endcase
        end
    end

    assign deliver = out_valid_q & out_ready;
    // Capture into an empty register, or into one being drained this cycle.
    assign cap     = ~reset & (req0 | req1) & (~out_valid_q | out_ready);

    always_comb begin
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cnt_d       = cnt_q;
        if (cap) begin
            out_data_d  = mux_out;
            out_valid_d = 1'b1;
            last_d      = sel;
        end else if (deliver) begin
            out_valid_d = 1'b0;
        end
        if (deliver) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 2'b00;
            cnt_q       <= '0;
        end else begin
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign selector   = sel;
    assign gnt0       = cap & ~sel;
    assign gnt1       = cap & sel;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Directed testbench for mux_2x1_arbiter. A second instance with a 2-bit
// counter shares all inputs and is used for the wrap check.

module tb_mux_2x1_arbiter;

    logic       clk;
    logic       reset;
    logic       req0, req1, out_ready;
    logic [1:0] data0, data1;

    logic       gnt0, gnt1, selector, out_valid;
    logic [1:0] out_data;
    logic [7:0] xfer_count;

    logic       w_gnt0, w_gnt1, w_selector, w_out_valid;
    logic [1:0] w_out_data;
    logic [1:0] w_xfer_count;

    int tests_run = 0;
    int tests_failed = 0;

    mux_2x1_arbiter #(
        .PwrC (0),
        .CNT_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .data0     (data0),
        .req1      (req1),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .selector  (selector),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .xfer_count(xfer_count)
    );

    mux_2x1_arbiter #(
        .PwrC (0),
        .CNT_W(2)
    ) dut_wrap (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .data0     (data0),
        .req1      (req1),
        .data1     (data1),
        .gnt0      (w_gnt0),
        .gnt1      (w_gnt1),
        .selector  (w_selector),
        .out_valid (w_out_valid),
        .out_data  (w_out_data),
        .out_ready (out_ready),
        .xfer_count(w_xfer_count)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset     = 1'b1;
        req0      = 1'b0;
        req1      = 1'b0;
        data0     = 2'b00;
        data1     = 2'b00;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req0      = 1'b0;
        req1      = 1'b0;
        data0     = 2'b00;
        data1     = 2'b00;
        out_ready = 1'b0;

        // Reset state and idle after release
        @(negedge clk);
        check("rst_selector", selector, 1);
        check("rst_gnt", {gnt1, gnt0}, 0);
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_gnt", {gnt1, gnt0}, 0);
            check("idle_valid", out_valid, 0);
            check("idle_data", out_data, 2'b00);
            check("idle_count", xfer_count, 0);
        end

        // Single request from requester 0
        @(posedge clk);
        #2;
        req0      = 1'b1;
        data0     = 2'b10;
        out_ready = 1'b1;
        @(negedge clk);
        check("single_gnt0", gnt0, 1);
        check("single_gnt1", gnt1, 0);
        check("single_sel", selector, 0);
        @(posedge clk);
        #2;
        req0 = 1'b0;
        @(negedge clk);
        check("single_gnt_after", gnt0, 0);
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 2'b10);
        @(negedge clk);
        check("single_count", xfer_count, 1);
        check("single_drained", out_valid, 0);

        // Contended round-robin
        apply_reset();
        req0      = 1'b1;
        req1      = 1'b1;
        data0     = 2'b01;
        data1     = 2'b11;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rr_gnt0", gnt0, (i % 2 == 0) ? 1 : 0);
            check("rr_gnt1", gnt1, (i % 2 == 1) ? 1 : 0);
            if (i > 0) check("rr_data", out_data, ((i - 1) % 2 == 0) ? 2'b01 : 2'b11);
            @(posedge clk);
            #2;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("rr_last_data", out_data, 2'b11);
        check("rr_last_valid", out_valid, 1);
        @(negedge clk);
        check("rr_count", xfer_count, 6);

        // Backpressure
        apply_reset();
        req1      = 1'b1;
        data1     = 2'b11;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_gnt1", gnt1, 1);
        @(posedge clk);
        #2;
        req1  = 1'b0;
        req0  = 1'b1;
        data0 = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_hold_data", out_data, 2'b11);
            check("bp_hold_valid", out_valid, 1);
            check("bp_gnt0_low", gnt0, 0);
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_gnt0", gnt0, 1);
        @(posedge clk);
        #2;
        req0 = 1'b0;
        @(negedge clk);
        check("bp_new_data", out_data, 2'b10);
        check("bp_count", xfer_count, 1);

        // Asynchronous reset mid-operation
        apply_reset();
        req0      = 1'b1;
        req1      = 1'b1;
        data0     = 2'b01;
        data1     = 2'b11;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        out_ready = 1'b0;
        @(negedge clk);
        check("mid_pre_valid", out_valid, 1);
        check("mid_pre_count", xfer_count, 2);
        #3;
        reset = 1'b1;
        #1;
        check("mid_valid_clr", out_valid, 0);
        check("mid_data_clr", out_data, 2'b00);
        check("mid_count_clr", xfer_count, 0);
        check("mid_sel", selector, 1);
        check("mid_gnt", {gnt1, gnt0}, 0);
        @(posedge clk);
        #2;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_first_gnt0", gnt0, 1);
        check("mid_first_gnt1", gnt1, 0);

        // Counter wrap on the 2-bit instance
        apply_reset();
        req0      = 1'b1;
        data0     = 2'b01;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("wrap_count2", w_xfer_count, 1);
        check("wrap_count8", xfer_count, 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
